// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between the requesters, the shared resource and wrr_arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface wrr_arbiter_if #(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]    requests;
    logic [N*WW-1:0] weights;
    logic            accepted;
    logic [N-1:0]    grants;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;

    modport master (
        output requests, weights, accepted,
        input  grants, grant_valid, grant_id
    );

    modport slave (
        input  requests, weights, accepted,
        output grants, grant_valid, grant_id
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each requester keeps the grant for up to its weight
// in accepted transfers, then the grant rotates; all outputs come straight from flops.
module wrr_arbiter #(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    wrr_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [WW:0] CREDIT_ONE = {{WW{1'b0}}, 1'b1};

    state_t         state_r;
    logic [IDW-1:0] cur_r;
    logic [IDW-1:0] ptr_r;
    logic [WW:0]    credit_r;
    logic [N-1:0]   grants_r;
    logic           grant_valid_r;
    logic [IDW-1:0] grant_id_r;

    logic [IDW-1:0] rot_ptr_s;
    logic [IDW-1:0] search_start_s;
    logic [IDW:0]   search_s;
    logic           win_found_s;
    logic [IDW-1:0] winner_s;
    logic [WW:0]    win_credit_s;
    logic           cur_req_s;
    logic           credit_left_s;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        logic [IDW-1:0] res;
        res = (idx == IDW'(N - 1)) ? {IDW{1'b0}} : idx + IDW'(1);
        return res;
    endfunction

    function automatic logic [WW:0] eff_weight(input logic [WW-1:0] w);
        logic [WW:0] res;
        res = (w == {WW{1'b0}}) ? CREDIT_ONE : {1'b0, w};
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] res;
        res = {{(N-1){1'b0}}, 1'b1} << idx;
        return res;
    endfunction

    // Returns {found, index}: first set request scanning start, start+1, ... modulo N.
    function automatic logic [IDW:0] find_winner(input logic [N-1:0]   req,
                                                 input logic [IDW-1:0] start);
        logic           found;
        logic           hit;
        logic [IDW-1:0] idx;
        int             cand;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand  = (int'(start) + k) % N;
            hit   = !found && req[cand[IDW-1:0]];
            idx   = hit ? cand[IDW-1:0] : idx;
            found = found | req[cand[IDW-1:0]];
        end
        return {found, idx};
    endfunction

    // In GRANT the only search that matters is the post-rotation one, so it starts after cur.
    always_comb begin
        rot_ptr_s      = wrap_inc(cur_r);
        search_start_s = (state_r == GRANT) ? rot_ptr_s : ptr_r;
        search_s       = find_winner(bus.requests, search_start_s);
        win_found_s    = search_s[IDW];
        winner_s       = search_s[IDW-1:0];
        win_credit_s   = eff_weight(bus.weights[winner_s*WW +: WW]);
        cur_req_s      = bus.requests[cur_r];
        credit_left_s  = (credit_r > CREDIT_ONE);
    end

    // State, credit bookkeeping and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cur_r         <= {IDW{1'b0}};
            ptr_r         <= {IDW{1'b0}};
            credit_r      <= {(WW+1){1'b0}};
            grants_r      <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {IDW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r       <= GRANT;
                        cur_r         <= winner_s;
                        credit_r      <= win_credit_s;
                        grants_r      <= onehot(winner_s);
                        grant_valid_r <= 1'b1;
                        grant_id_r    <= winner_s;
                    end else begin
                        grants_r      <= {N{1'b0}};
                        grant_valid_r <= 1'b0;
                        grant_id_r    <= {IDW{1'b0}};
                    end
                end
                GRANT: begin
                    if (bus.accepted && credit_left_s && cur_req_s) begin
                        credit_r <= credit_r - CREDIT_ONE;
                    end else if (bus.accepted) begin
                        // Rotation: an accept with a dropped request still counts.
                        ptr_r <= rot_ptr_s;
                        if (win_found_s) begin
                            cur_r         <= winner_s;
                            credit_r      <= win_credit_s;
                            grants_r      <= onehot(winner_s);
                            grant_valid_r <= 1'b1;
                            grant_id_r    <= winner_s;
                        end else begin
                            state_r       <= IDLE;
                            credit_r      <= {(WW+1){1'b0}};
                            grants_r      <= {N{1'b0}};
                            grant_valid_r <= 1'b0;
                            grant_id_r    <= {IDW{1'b0}};
                        end
                    end else if (!cur_req_s) begin
                        state_r       <= IDLE;
                        ptr_r         <= rot_ptr_s;
                        credit_r      <= {(WW+1){1'b0}};
                        grants_r      <= {N{1'b0}};
                        grant_valid_r <= 1'b0;
                        grant_id_r    <= {IDW{1'b0}};
                    end else begin
                        credit_r <= credit_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    credit_r      <= {(WW+1){1'b0}};
                    grants_r      <= {N{1'b0}};
                    grant_valid_r <= 1'b0;
                    grant_id_r    <= {IDW{1'b0}};
                end
            endcase
        end
    end

    assign bus.grants      = grants_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_id    = grant_id_r;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: a behavioural model queues the expected outputs
// for every driven cycle, and they are compared after the following clock edge.
module tb_wrr_arbiter;
    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
        logic [N-1:0]   g;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    wrr_arbiter_if #(.N(N), .WW(WW), .IDW(IDW)) bus ();

    wrr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_busy   = 0;
    int m_cur    = 0;
    int m_credit = 0;
    int m_ptr    = 0;

    int seq_a[10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
    int seq_b[10] = '{0, 1, 2, 2, 2, 3, 0, 1, 2, 3};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_w(input int i);
        int w;
        w = int'(bus.weights[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int search(input int start, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] req, input logic acc);
        int w;
        if (r) begin
            m_busy = 0; m_cur = 0; m_credit = 0; m_ptr = 0;
        end else if (m_busy == 0) begin
            w = search(m_ptr, req);
            if (w >= 0) begin
                m_busy = 1; m_cur = w; m_credit = eff_w(w);
            end
        end else if (acc && m_credit > 1 && req[m_cur]) begin
            m_credit--;
        end else if (acc) begin
            m_ptr = (m_cur + 1) % N;
            w = search(m_ptr, req);
            if (w >= 0) begin
                m_cur = w; m_credit = eff_w(w);
            end else begin
                m_busy = 0;
            end
        end else if (!req[m_cur]) begin
            m_ptr  = (m_cur + 1) % N;
            m_busy = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] req, input logic acc);
        exp_t e;
        rst          = r;
        bus.requests = req;
        bus.accepted = acc;
        model_step(r, req, acc);
        e.v  = (m_busy != 0);
        e.id = (m_busy != 0) ? IDW'(m_cur) : '0;
        e.g  = (m_busy != 0) ? (N'(1) << m_cur) : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("grants", 32'(bus.grants), 32'(e.g));
        check_val("grant_valid", 32'(bus.grant_valid), 32'(e.v));
        check_val("grant_id", 32'(bus.grant_id), 32'(e.id));
    endtask

    initial begin
        rst          = 1'b1;
        bus.requests = '0;
        bus.accepted = 1'b0;
        bus.weights  = {4{4'd2}};
        @(negedge clk);

        // Reset state
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);
        check_val("reset_grants", 32'(bus.grants), 32'd0);

        // Single requester, weight 2, accept every cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b0100, 1'b1);
            check_val("single_id", 32'(bus.grant_id), 32'd2);
            check_val("single_grant", 32'(bus.grants), 32'h4);
        end

        // All requesting, weights {1,2,3,1}
        bus.weights = {4'd1, 4'd3, 4'd2, 4'd1};
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            check_val("seq_1231", 32'(bus.grant_id), 32'(seq_a[i]));
            check_val("no_idle", 32'(bus.grant_valid), 32'd1);
        end

        // Hold without accept, then rotate
        bus.weights = {4{4'd1}};
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1010, 1'b0);
            check_val("hold", 32'(bus.grants), 32'h2);
        end
        cycle(1'b0, 4'b1010, 1'b1);
        check_val("hold_rot", 32'(bus.grants), 32'h8);

        // Withdrawal of requester 3 with requester 0 waiting
        cycle(1'b0, 4'b0001, 1'b0);
        check_val("wd_idle", 32'(bus.grants), 32'd0);
        cycle(1'b0, 4'b0001, 1'b0);
        check_val("wd_next", 32'(bus.grants), 32'h1);

        // Weight 0 acts as 1; mid-grant weight change does not touch live credit
        bus.weights = {4'd1, 4'd3, 4'd0, 4'd1};
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.weights[2*WW +: WW] = 4'd1;
            cycle(1'b0, 4'b1111, 1'b1);
            check_val("seq_wchg", 32'(bus.grant_id), 32'(seq_b[i]));
        end

        // Reset while granting with an accept in flight
        bus.weights = {4{4'd3}};
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        check_val("pre_rst", 32'(bus.grants), 32'h4);
        cycle(1'b1, 4'b0100, 1'b1);
        check_val("rst_drop", 32'(bus.grants), 32'd0);
        cycle(1'b0, 4'b1111, 1'b0);
        check_val("post_rst", 32'(bus.grants), 32'h1);

        // Accept coinciding with the request falling still rotates
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        check_val("acc_drop", 32'(bus.grants), 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bus.weights = 16'($urandom);
            cycle(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
